muldiv: RTL and testbench

Iterative RV32M/RV64M multiply/divide unit sitting beside the ALU in the EX stage of the five-stage `cpu` pipeline. It accepts one M-extension operation per start pulse and computes it over several cycles, `UNROLL` bits per cycle. While it works, `busy` drives the hazard unit to pause the PC and freeze IF/ID and ID/EX. It then pulses `done` with the result for the EX/MEM register.

---
 rtl/muldiv_pkg.sv | 38 +++
 rtl/muldiv_step.sv | 45 ++++
 rtl/muldiv.sv | 180 ++++++++++++++++++
 tb/tb_muldiv.sv | 271 +++++++++++++++++++++++++++
 4 files changed

// File: rtl/muldiv_pkg.sv
// muldiv_pkg: shared M-extension op encodings, FSM states and decode helpers.
// Used by the muldiv unit and the ID-stage decoder.
package muldiv_pkg;

   localparam logic [2:0] OP_MUL    = 3'd0;
   localparam logic [2:0] OP_MULH   = 3'd1;
   localparam logic [2:0] OP_MULHSU = 3'd2;
   localparam logic [2:0] OP_MULHU  = 3'd3;
   localparam logic [2:0] OP_DIV    = 3'd4;
   localparam logic [2:0] OP_DIVU   = 3'd5;
   localparam logic [2:0] OP_REM    = 3'd6;
   localparam logic [2:0] OP_REMU   = 3'd7;

   // one bit per funct3 value, bit index = op
   localparam logic [7:0] OP_IS_DIV   = 8'b1111_0000;
   localparam logic [7:0] OP_SIGNED_A = 8'b0101_0110;
   localparam logic [7:0] OP_SIGNED_B = 8'b0101_0010;

   typedef enum logic [1:0] {
      S_IDLE,
      S_CALC,
      S_FIX,
      S_DONE
   } state_t;

   function automatic logic op_is_div(input logic [2:0] op);
      return OP_IS_DIV[op];
   endfunction

   function automatic logic op_signed_a(input logic [2:0] op);
      return OP_SIGNED_A[op];
   endfunction

   function automatic logic op_signed_b(input logic [2:0] op);
      return OP_SIGNED_B[op];
   endfunction

endpackage

// File: rtl/muldiv_step.sv
// muldiv_step: one combinational radix-2 step on the {hi,lo} register pair.
// Ports: i_div (divide step, only with MULDIV_DIV_EN), i_hi/i_lo (state), i_b (operand), o_hi/o_lo.
module muldiv_step #(
   parameter int XLEN = 32
) (
`ifdef MULDIV_DIV_EN
   input  logic            i_div,
`endif
   input  logic [XLEN-1:0] i_hi,
   input  logic [XLEN-1:0] i_lo,
   input  logic [XLEN-1:0] i_b,
   output logic [XLEN-1:0] o_hi,
   output logic [XLEN-1:0] o_lo
);

   logic [XLEN:0]   w_sum;
`ifdef MULDIV_DIV_EN
   logic [XLEN:0]   w_trial;
   logic [XLEN-1:0] w_diff;
`endif

   always_comb begin
      // multiply: add multiplicand when the low multiplier bit is set,
      // then shift {carry,hi,lo} right by one
      w_sum = {1'b0, i_hi} + (i_lo[0] ? {1'b0, i_b} : '0);
      o_hi  = w_sum[XLEN:1];
      o_lo  = {w_sum[0], i_lo[XLEN-1:1]};
`ifdef MULDIV_DIV_EN
      // divide: shift next dividend bit into the remainder, trial subtract;
      // remainder < divisor keeps the difference within XLEN bits
      w_trial = {i_hi, i_lo[XLEN-1]};
      w_diff  = w_trial[XLEN-1:0] - i_b;
      if (i_div) begin
         if (w_trial >= {1'b0, i_b}) begin
            o_hi = w_diff;
            o_lo = {i_lo[XLEN-2:0], 1'b1};
         end else begin
            o_hi = w_trial[XLEN-1:0];
            o_lo = {i_lo[XLEN-2:0], 1'b0};
         end
      end
`endif
   end

endmodule

// File: rtl/muldiv.sv
// muldiv: iterative RV32M/RV64M multiply/divide unit, UNROLL steps per cycle.
// Ports: clock, reset (async active-low), start/op/rs1/rs2, flush -> busy, done, result, illegal.
// MULDIV_DIV_EN enables division; without it divide ops complete at once with illegal=1.
module muldiv
   import muldiv_pkg::*;
#(
   parameter int XLEN   = 32,
   parameter int UNROLL = 1
) (
   input  logic            clock,
   input  logic            reset,
   input  logic            start,
   input  logic [2:0]      op,
   input  logic [XLEN-1:0] rs1,
   input  logic [XLEN-1:0] rs2,
   input  logic            flush,
   output logic            busy,
   output logic            done,
   output logic [XLEN-1:0] result,
   output logic            illegal
);

   localparam int STEPS = XLEN / UNROLL;
   localparam int CNT_W = $clog2(STEPS);

   state_t            r_state;
   state_t            w_state_nxt;
   logic [CNT_W-1:0]  r_cnt;
   logic [2:0]        r_op;
   logic [XLEN-1:0]   r_hi;
   logic [XLEN-1:0]   r_lo;
   logic [XLEN-1:0]   r_b;
   logic              r_neg_q;
`ifdef MULDIV_DIV_EN
   logic              r_neg_r;
`endif
   logic [XLEN-1:0]   r_result;
   logic              r_illegal;

   logic              w_accept;
   logic              w_div;
   logic              w_a_neg;
   logic              w_b_neg;
   logic [XLEN-1:0]   w_a_mag;
   logic [XLEN-1:0]   w_b_mag;
   logic              w_fast;
   logic              w_fast_ill;
   logic [XLEN-1:0]   w_fast_res;
   logic [2*XLEN-1:0] w_prod;
   logic [XLEN-1:0]   w_fix_res;

   logic [XLEN-1:0]   w_hi [UNROLL+1];
   logic [XLEN-1:0]   w_lo [UNROLL+1];

   assign w_hi[0] = r_hi;
   assign w_lo[0] = r_lo;

   for (genvar k = 0; k < UNROLL; k++) begin : g_step
      muldiv_step #(.XLEN(XLEN)) u_step (
`ifdef MULDIV_DIV_EN
         .i_div (op_is_div(r_op)),
`endif
         .i_hi  (w_hi[k]),
         .i_lo  (w_lo[k]),
         .i_b   (r_b),
         .o_hi  (w_hi[k+1]),
         .o_lo  (w_lo[k+1])
      );
   end

   // operand decode and fast paths at accept time
   always_comb begin
      w_div      = op_is_div(op);
      w_a_neg    = op_signed_a(op) & rs1[XLEN-1];
      w_b_neg    = op_signed_b(op) & rs2[XLEN-1];
      w_a_mag    = w_a_neg ? -rs1 : rs1;
      w_b_mag    = w_b_neg ? -rs2 : rs2;
      w_fast     = 1'b0;
      w_fast_ill = 1'b0;
      w_fast_res = '0;
`ifdef MULDIV_DIV_EN
      // op[1] distinguishes REM/REMU from DIV/DIVU
      if (w_div && rs2 == '0) begin
         w_fast     = 1'b1;
         w_fast_res = op[1] ? rs1 : '1;
      end else if (w_div && op_signed_b(op) &&
                   rs1 == {1'b1, {(XLEN-1){1'b0}}} && rs2 == '1) begin
         w_fast     = 1'b1;
         w_fast_res = op[1] ? '0 : rs1;
      end
`else
      if (w_div) begin
         w_fast     = 1'b1;
         w_fast_ill = 1'b1;
      end
`endif
   end

   // sign fix-up and word select
   always_comb begin
      w_prod = {r_hi, r_lo};
      if (r_neg_q)
         w_prod = -w_prod;
      w_fix_res = (r_op == OP_MUL) ? w_prod[XLEN-1:0]
                                   : w_prod[2*XLEN-1:XLEN];
`ifdef MULDIV_DIV_EN
      if (op_is_div(r_op)) begin
         if (r_op[1])
            w_fix_res = r_neg_r ? -r_hi : r_hi;
         else
            w_fix_res = r_neg_q ? -r_lo : r_lo;
      end
`endif
   end

   always_comb begin
      w_state_nxt = r_state;
      w_accept    = start && !flush &&
                    (r_state == S_IDLE || r_state == S_DONE);
      unique case (r_state)
         S_IDLE, S_DONE: begin
            w_state_nxt = S_IDLE;
            if (w_accept)
               w_state_nxt = w_fast ? S_DONE : S_CALC;
         end
         S_CALC: if (r_cnt == '0) w_state_nxt = S_FIX;
         S_FIX:  w_state_nxt = S_DONE;
         default: w_state_nxt = S_IDLE;
      endcase
      if (flush)
         w_state_nxt = S_IDLE;
   end

   always_ff @(posedge clock or negedge reset) begin
      if (!reset) begin
         r_state   <= S_IDLE;
         r_cnt     <= '0;
         r_op      <= OP_MUL;
         r_hi      <= '0;
         r_lo      <= '0;
         r_b       <= '0;
         r_neg_q   <= 1'b0;
`ifdef MULDIV_DIV_EN
         r_neg_r   <= 1'b0;
`endif
         r_result  <= '0;
         r_illegal <= 1'b0;
      end else begin
         r_state <= w_state_nxt;
         if (w_accept) begin
            r_op    <= op;
            r_cnt   <= CNT_W'(STEPS - 1);
            r_hi    <= '0;
            r_lo    <= w_div ? w_a_mag : w_b_mag;
            r_b     <= w_div ? w_b_mag : w_a_mag;
            r_neg_q <= w_a_neg ^ w_b_neg;
`ifdef MULDIV_DIV_EN
            r_neg_r <= w_a_neg;
`endif
            if (w_fast) begin
               r_result  <= w_fast_res;
               r_illegal <= w_fast_ill;
            end
         end else if (r_state == S_CALC && !flush) begin
            r_hi  <= w_hi[UNROLL];
            r_lo  <= w_lo[UNROLL];
            r_cnt <= r_cnt - 1'b1;
         end else if (r_state == S_FIX && !flush) begin
            r_result  <= w_fix_res;
            r_illegal <= 1'b0;
         end
      end
   end

   assign busy    = (r_state == S_CALC) || (r_state == S_FIX);
   assign done    = (r_state == S_DONE);
   assign result  = r_result;
   assign illegal = done & r_illegal;

endmodule

// File: tb/tb_muldiv.sv
// tb_muldiv: scoreboard bench for muldiv (XLEN=32, UNROLL=1).
// Divide expectations follow MULDIV_DIV_EN.
module tb_muldiv;
   import muldiv_pkg::*;

   logic        clock = 1'b0;
   logic        reset;
   logic        start;
   logic [2:0]  op;
   logic [31:0] rs1;
   logic [31:0] rs2;
   logic        flush;
   logic        busy;
   logic        done;
   logic [31:0] result;
   logic        illegal;

   int n_vec  = 0;
   int n_miss = 0;
   logic [31:0] last_res = '0;

   typedef struct {
      logic [31:0] res;
      logic        ill;
      int          lat;
   } exp_t;

   exp_t sb_q[$];

   muldiv #(.XLEN(32), .UNROLL(1)) dut (
      .clock   (clock),
      .reset   (reset),
      .start   (start),
      .op      (op),
      .rs1     (rs1),
      .rs2     (rs2),
      .flush   (flush),
      .busy    (busy),
      .done    (done),
      .result  (result),
      .illegal (illegal)
   );

   always #5 clock = ~clock;

   task automatic chk(input string tag, input logic [63:0] got,
                      input logic [63:0] exp);
      n_vec++;
      if (got !== exp) begin
         n_miss++;
         $display("FAIL %s: got %0h expected %0h", tag, got, exp);
      end
   endtask

   function automatic exp_t model(input logic [2:0] o,
                                  input logic [31:0] a,
                                  input logic [31:0] b);
      exp_t e;
      longint unsigned p;
      longint sp;
      int sa;
      int sb;
      sa = a;
      sb = b;
      e.res = '0;
      e.ill = 1'b0;
      e.lat = 34;
      p = {32'b0, a} * {32'b0, b};
      case (o)
         OP_MUL:  e.res = p[31:0];
         OP_MULHU: e.res = p[63:32];
         OP_MULH: begin
            sp = longint'(sa) * longint'(sb);
            e.res = sp[63:32];
         end
         OP_MULHSU: begin
            sp = longint'(sa) * longint'({32'b0, b});
            e.res = sp[63:32];
         end
         default: begin
`ifdef MULDIV_DIV_EN
            if (b == 32'd0) begin
               e.lat = 1;
               e.res = o[1] ? a : 32'hFFFF_FFFF;
            end else if ((o == OP_DIV || o == OP_REM) &&
                         a == 32'h8000_0000 && b == 32'hFFFF_FFFF) begin
               e.lat = 1;
               e.res = (o == OP_DIV) ? a : 32'd0;
            end else if (o == OP_DIV) e.res = sa / sb;
            else if (o == OP_REM)     e.res = sa % sb;
            else if (o == OP_DIVU)    e.res = a / b;
            else                      e.res = a % b;
`else
            e.lat = 1;
            e.ill = 1'b1;
            e.res = 32'd0;
`endif
         end
      endcase
      return e;
   endfunction

   task automatic issue(input logic [2:0] o, input logic [31:0] a,
                        input logic [31:0] b);
      sb_q.push_back(model(o, a, b));
      op    = o;
      rs1   = a;
      rs2   = b;
      start = 1'b1;
      @(posedge clock);
      #1;
      start = 1'b0;
   endtask

   // n0: cycles already elapsed since the accepting edge (busy all along)
   task automatic wait_done(input int n0);
      int   n;
      int   nb;
      exp_t e;
      n  = n0;
      nb = n0 - 1;
      while (!done && n < 200) begin
         if (busy) nb++;
         @(posedge clock);
         #1;
         n++;
      end
      if (sb_q.size() == 0) begin
         chk("scoreboard_empty", 1, 0);
      end else begin
         e = sb_q.pop_front();
         if (!done) begin
            chk("done_timeout", 0, 1);
         end else begin
            chk("result", result, e.res);
            chk("illegal", illegal, e.ill);
            chk("latency", n, e.lat);
            chk("busy_cycles", nb, e.lat - 1);
            last_res = e.res;
         end
      end
   endtask

   initial begin
      logic [2:0]  ro;
      logic [31:0] ra;
      logic [31:0] rb;
      logic        seen;
      reset = 1'b0;
      start = 1'b0;
      flush = 1'b0;
      op    = '0;
      rs1   = '0;
      rs2   = '0;
      #1;
      chk("rst_busy", busy, 0);
      chk("rst_done", done, 0);
      chk("rst_result", result, 0);
      chk("rst_illegal", illegal, 0);
      repeat (3) @(posedge clock);
      @(negedge clock);
      reset = 1'b1;
      @(posedge clock);
      #1;

      // directed vectors, issued back to back on each done cycle
      issue(OP_MUL, 32'd7, 32'hFFFF_FFFD);          wait_done(1);
      issue(OP_MULH, 32'h8000_0000, 32'h8000_0000); wait_done(1);
      issue(OP_MULHU, 32'hFFFF_FFFF, 32'hFFFF_FFFF); wait_done(1);
      issue(OP_MULHSU, 32'hFFFF_FFFF, 32'hFFFF_FFFF); wait_done(1);
      issue(OP_DIV, 32'hFFFF_FFF9, 32'd2);           wait_done(1);
      issue(OP_REM, 32'hFFFF_FFF9, 32'd2);           wait_done(1);
      issue(OP_DIVU, 32'd100, 32'd7);                wait_done(1);
      issue(OP_REMU, 32'd100, 32'd7);                wait_done(1);
      issue(OP_DIVU, 32'd5, 32'd0);                  wait_done(1);
      issue(OP_REM, 32'd5, 32'd0);                   wait_done(1);
      issue(OP_DIV, 32'h8000_0000, 32'hFFFF_FFFF);   wait_done(1);
      issue(OP_REM, 32'h8000_0000, 32'hFFFF_FFFF);   wait_done(1);
      issue(OP_MUL, 32'h1234_5678, 32'h9ABC_DEF0);   wait_done(1);

      // start during CALC is ignored
      repeat (2) @(posedge clock);
      #1;
      issue(OP_MULHU, 32'h0000_0003, 32'h0000_0005);
      repeat (4) @(posedge clock);
      #1;
      op    = OP_MUL;
      rs1   = 32'hFFFF_FFFF;
      rs2   = 32'h1234_0000;
      start = 1'b1;
      @(posedge clock);
      #1;
      start = 1'b0;
      wait_done(6);

      // flush at cycle 10 of a multiply
      @(posedge clock);
      #1;
      issue(OP_MUL, 32'h0000_1234, 32'h0000_5678);
      repeat (9) @(posedge clock);
      #1;
      flush = 1'b1;
      @(posedge clock);
      #1;
      flush = 1'b0;
      chk("flush_busy", busy, 0);
      chk("flush_done", done, 0);
      chk("flush_result", result, last_res);
      void'(sb_q.pop_front());
      seen = 1'b0;
      repeat (40) begin
         @(posedge clock);
         #1;
         if (done) seen = 1'b1;
      end
      chk("flush_no_done", seen, 0);
      issue(OP_MULH, 32'hFFFF_FF00, 32'h0001_0000); wait_done(1);

      // flush beats a simultaneous start
      @(posedge clock);
      #1;
      op    = OP_MUL;
      rs1   = 32'd3;
      rs2   = 32'd4;
      start = 1'b1;
      flush = 1'b1;
      @(posedge clock);
      #1;
      start = 1'b0;
      flush = 1'b0;
      chk("flush_start_busy", busy, 0);
      chk("flush_start_done", done, 0);

      // random mix
      for (int i = 0; i < 16; i++) begin
         ro = 3'($urandom_range(0, 7));
         ra = $urandom;
         rb = $urandom;
         if ($urandom_range(0, 5) == 0) rb = 32'd0;
         if ($urandom_range(0, 5) == 0) begin
            ra = 32'h8000_0000;
            rb = 32'hFFFF_FFFF;
         end
         if ($urandom_range(0, 3) == 0) rb = rb >> 20;
         issue(ro, ra, rb);
         wait_done(1);
      end

      // reset mid-CALC clears every output immediately
      issue(OP_MUL, 32'd7, 32'd9);
      repeat (5) @(posedge clock);
      #1;
      reset = 1'b0;
      #1;
      chk("midrst_busy", busy, 0);
      chk("midrst_done", done, 0);
      chk("midrst_result", result, 0);
      chk("midrst_illegal", illegal, 0);
      void'(sb_q.pop_front());
      @(negedge clock);
      reset = 1'b1;
      @(posedge clock);
      #1;
      issue(OP_MUL, 32'd11, 32'd13); wait_done(1);
      issue(OP_DIV, 32'd50, 32'd5);  wait_done(1);

      $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_miss);
      $finish;
   end

endmodule
